wbu: RTL and testbench

//  Write-back stage directly downstream of the LSU. It registers each retiring instruction: EXU result or
//  LSU load data (o_regld), rd index, write enable and PC. It then drives the register-file write port and
//  a one-cycle commit pulse for difftest.
//  A 2-entry skid buffer decouples the upstream valid/ready handshake from a downstream stall (i_stall).

---
 rtl/wbu.sv | 141 ++++++++++++++
 tb/tb_wbu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wbu.sv
// Write-back stage: registers retiring instructions from the LSU, drives the register-file write port
// and a per-instruction commit pulse, with a 2-entry skid buffer absorbing downstream stalls.
module wbu #(
   parameter int CPU_WIDTH = 32,
   parameter int REG_ADDRW = 5
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [CPU_WIDTH-1:0] i_pc,
   input  logic [REG_ADDRW-1:0] i_rdid,
   input  logic                 i_rdwen,
   input  logic                 i_ldsel,
   input  logic [CPU_WIDTH-1:0] i_exu_res,
   input  logic [CPU_WIDTH-1:0] i_lsu_regld,
   input  logic                 i_stall,
   output logic                 o_rdwen,
   output logic [REG_ADDRW-1:0] o_rdid,
   output logic [CPU_WIDTH-1:0] o_rd,
   output logic                 o_commit,
   output logic [CPU_WIDTH-1:0] o_pc
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;

   logic [1:0]           r_state;
   logic [1:0]           w_state_nxt;

   logic [CPU_WIDTH-1:0] r_main_pc;
   logic [REG_ADDRW-1:0] r_main_rdid;
   logic                 r_main_rdwen;
   logic [CPU_WIDTH-1:0] r_main_data;

   logic [CPU_WIDTH-1:0] r_skid_pc;
   logic [REG_ADDRW-1:0] r_skid_rdid;
   logic                 r_skid_rdwen;
   logic [CPU_WIDTH-1:0] r_skid_data;

   logic                 w_main_valid;
   logic                 w_skid_valid;
   logic                 w_acc;
   logic                 w_ret;
   logic [CPU_WIDTH-1:0] w_in_data;
   logic                 w_load_main;
   logic                 w_load_skid;
   logic                 w_skid_to_main;

   assign w_main_valid = (r_state == S_ONE) || (r_state == S_TWO);
   assign w_skid_valid = (r_state == S_TWO);

   // Ready depends only on stored state, so the upstream never sees a combinational path from stall.
   assign o_ready   = ~w_skid_valid;
   assign w_acc     = i_valid & o_ready;
   assign w_ret     = w_main_valid & ~i_stall & ~i_rst;
   assign w_in_data = i_ldsel ? i_lsu_regld : i_exu_res;

   always_comb begin
      w_state_nxt    = r_state;
      w_load_main    = 1'b0;
      w_load_skid    = 1'b0;
      w_skid_to_main = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_acc) begin
               w_load_main = 1'b1;
               w_state_nxt = S_ONE;
            end
         end
         S_ONE: begin
            if (w_acc && w_ret) begin
               w_load_main = 1'b1;
            end else if (w_acc) begin
               w_load_skid = 1'b1;
               w_state_nxt = S_TWO;
            end else if (w_ret) begin
               w_state_nxt = S_EMPTY;
            end
         end
         S_TWO: begin
            if (w_ret) begin
               w_skid_to_main = 1'b1;
               w_state_nxt    = S_ONE;
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // MAIN is filled either straight from the input or by promoting the SKID entry.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_main_pc    <= '0;
         r_main_rdid  <= '0;
         r_main_rdwen <= 1'b0;
         r_main_data  <= '0;
      end else if (w_load_main) begin
         r_main_pc    <= i_pc;
         r_main_rdid  <= i_rdid;
         r_main_rdwen <= i_rdwen;
         r_main_data  <= w_in_data;
      end else if (w_skid_to_main) begin
         r_main_pc    <= r_skid_pc;
         r_main_rdid  <= r_skid_rdid;
         r_main_rdwen <= r_skid_rdwen;
         r_main_data  <= r_skid_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_skid_pc    <= '0;
         r_skid_rdid  <= '0;
         r_skid_rdwen <= 1'b0;
         r_skid_data  <= '0;
      end else if (w_load_skid) begin
         r_skid_pc    <= i_pc;
         r_skid_rdid  <= i_rdid;
         r_skid_rdwen <= i_rdwen;
         r_skid_data  <= w_in_data;
      end
   end

   // Writes to x0 are dropped here so the register file never needs to special-case them.
   assign o_commit = w_ret;
   assign o_rdwen  = w_ret & r_main_rdwen & (r_main_rdid != '0);
   assign o_rdid   = r_main_rdid;
   assign o_rd     = r_main_data;
   assign o_pc     = r_main_pc;

endmodule

// File: tb/tb_wbu.sv
// Scoreboard bench for wbu: the driver queues expected commits on acceptance, a negedge monitor checks them.
module tb_wbu;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        iValid = 1'b0;
   logic        oReady;
   logic [31:0] iPc = '0;
   logic [4:0]  iRdid = '0;
   logic        iRdwen = 1'b0;
   logic        iLdsel = 1'b0;
   logic [31:0] iExuRes = '0;
   logic [31:0] iLsuRegld = '0;
   logic        iStall = 1'b0;
   logic        oRdwen;
   logic [4:0]  oRdid;
   logic [31:0] oRd;
   logic        oCommit;
   logic [31:0] oPc;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rdid;
      logic        rdwen;
      logic [31:0] rd;
   } expEntry_t;

   expEntry_t sbQueue[$];
   int  total = 0;
   int  bad = 0;
   int  commitCount = 0;
   bit  monitorOn = 1'b0;

   always #5 clock = ~clock;

   wbu #(.CPU_WIDTH(32), .REG_ADDRW(5)) dut (
      .i_clk(clock), .i_rst(reset), .i_valid(iValid), .o_ready(oReady),
      .i_pc(iPc), .i_rdid(iRdid), .i_rdwen(iRdwen), .i_ldsel(iLdsel),
      .i_exu_res(iExuRes), .i_lsu_regld(iLsuRegld), .i_stall(iStall),
      .o_rdwen(oRdwen), .o_rdid(oRdid), .o_rd(oRd), .o_commit(oCommit), .o_pc(oPc)
   );

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: every commit must match the oldest accepted instruction, in order.
   always @(negedge clock) begin
      if (monitorOn) begin
         if (oCommit) begin
            commitCount++;
            if (sbQueue.size() == 0) begin
               checkOutput("spuriousCommit", 64'(oPc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               expEntry_t e;
               e = sbQueue.pop_front();
               checkOutput("commitPc", 64'(oPc), 64'(e.pc));
               checkOutput("commitRdwen", 64'(oRdwen), 64'(e.rdwen));
               checkOutput("commitRdid", 64'(oRdid), 64'(e.rdid));
               checkOutput("commitRd", 64'(oRd), 64'(e.rd));
            end
         end else if (oRdwen) begin
            checkOutput("rdwenWithoutCommit", 64'(oRdwen), 64'd0);
         end
      end
   end

   // One cycle of stimulus, entered and left just after a rising edge.
   task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [4:0] rdid,
                                input logic rdwen, input logic ldsel, input logic [31:0] exu,
                                input logic [31:0] lsu, input logic stall,
                                output logic sawReady, output logic sawCommit, output logic sawRdwen);
      expEntry_t e;
      iValid = valid; iPc = pc; iRdid = rdid; iRdwen = rdwen; iLdsel = ldsel;
      iExuRes = exu; iLsuRegld = lsu; iStall = stall;
      @(negedge clock);
      sawReady = oReady; sawCommit = oCommit; sawRdwen = oRdwen;
      if (valid && oReady) begin
         e.pc = pc; e.rdid = rdid; e.rdwen = rdwen && (rdid != 5'd0); e.rd = ldsel ? lsu : exu;
         sbQueue.push_back(e);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idleCycle(input logic stall, output logic sawReady, output logic sawCommit, output logic sawRdwen);
      applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, stall, sawReady, sawCommit, sawRdwen);
   endtask

   task automatic applyReset();
      reset = 1'b1; iValid = 1'b0;
      @(negedge clock);
      checkOutput("resetCycleCommit", 64'(oCommit), 64'd0);
      checkOutput("resetCycleRdwen", 64'(oRdwen), 64'd0);
      @(posedge clock);
      sbQueue.delete();
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("postResetReady", 64'(oReady), 64'd1);
      checkOutput("postResetCommit", 64'(oCommit), 64'd0);
      checkOutput("postResetRdid", 64'(oRdid), 64'd0);
      checkOutput("postResetRd", 64'(oRd), 64'd0);
      checkOutput("postResetPc", 64'(oPc), 64'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic r, c, w;
      int startCount;
      int tries;
      logic        pend;
      logic [31:0] pPc, pExu, pLsu;
      logic [4:0]  pRdid;
      logic        pRdwen, pLdsel, pStall;

      repeat (2) @(posedge clock);
      #1;
      monitorOn = 1'b1;
      applyReset();

      // Load with sign-extended data, committing one cycle after acceptance.
      applyStimulus(1'b1, 32'h8000_0000, 5'd5, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hFFFF_FF80, 1'b0, r, c, w);
      checkOutput("t1Ready", 64'(r), 64'd1);
      idleCycle(1'b0, r, c, w);
      checkOutput("t1Commit", 64'(c), 64'd1);
      checkOutput("t1Rdwen", 64'(w), 64'd1);

      // Write to x0 still commits but never drives the write enable.
      applyStimulus(1'b1, 32'h8000_0004, 5'd0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 1'b0, r, c, w);
      idleCycle(1'b0, r, c, w);
      checkOutput("t2Commit", 64'(c), 64'd1);
      checkOutput("t2Rdwen", 64'(w), 64'd0);
      idleCycle(1'b0, r, c, w);
      checkOutput("t2NoRepeat", 64'(c), 64'd0);

      // Backpressure: two absorbed under stall, third refused until stall releases.
      applyStimulus(1'b1, 32'h0, 5'd1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, r, c, w);
      checkOutput("t3Ready0", 64'(r), 64'd1);
      applyStimulus(1'b1, 32'h4, 5'd2, 1'b1, 1'b1, 32'h0, 32'h204, 1'b1, r, c, w);
      checkOutput("t3Ready1", 64'(r), 64'd1);
      checkOutput("t3StallNoCommit", 64'(c), 64'd0);
      applyStimulus(1'b1, 32'h8, 5'd3, 1'b1, 1'b0, 32'h308, 32'h0, 1'b1, r, c, w);
      checkOutput("t3Ready2", 64'(r), 64'd0);
      startCount = commitCount;
      tries = 0;
      r = 1'b0;
      while (!r && tries < 10) begin
         applyStimulus(1'b1, 32'h8, 5'd3, 1'b1, 1'b0, 32'h308, 32'h0, 1'b0, r, c, w);
         tries++;
      end
      checkOutput("t3ThirdAccepted", 64'(r), 64'd1);
      repeat (4) idleCycle(1'b0, r, c, w);
      checkOutput("t3CommitCount", 64'(commitCount - startCount), 64'd3);
      checkOutput("t3Drained", 64'(sbQueue.size()), 64'd0);

      // Streaming: eight back-to-back, no bubbles.
      startCount = commitCount;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 32'h1000 + 32'(i * 4), 5'(i + 1), 1'(i % 3 != 0), 1'(i % 2),
                       32'hA000 + 32'(i), 32'hB000 + 32'(i), 1'b0, r, c, w);
         checkOutput("t4Ready", 64'(r), 64'd1);
         if (i > 0) checkOutput("t4Commit", 64'(c), 64'd1);
      end
      idleCycle(1'b0, r, c, w);
      checkOutput("t4LastCommit", 64'(c), 64'd1);
      checkOutput("t4CommitCount", 64'(commitCount - startCount), 64'd8);

      // Reset while both entries are held: neither may ever commit.
      applyStimulus(1'b1, 32'h2000, 5'd7, 1'b1, 1'b0, 32'h7777, 32'h0, 1'b1, r, c, w);
      applyStimulus(1'b1, 32'h2004, 5'd8, 1'b1, 1'b0, 32'h8888, 32'h0, 1'b1, r, c, w);
      idleCycle(1'b1, r, c, w);
      checkOutput("t5FullReady", 64'(r), 64'd0);
      startCount = commitCount;
      applyReset();
      repeat (4) idleCycle(1'b0, r, c, w);
      checkOutput("t5NoCommitAfterReset", 64'(commitCount - startCount), 64'd0);

      // Random valid/stall traffic against the scoreboard; payload held until accepted.
      pend = 1'b0;
      pPc = '0; pExu = '0; pLsu = '0; pRdid = '0; pRdwen = 1'b0; pLdsel = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!pend && ($urandom_range(0, 3) != 0)) begin
            pend = 1'b1;
            pPc = 32'h4000_0000 + 32'(cyc * 4);
            pRdid = 5'($urandom_range(0, 31));
            pRdwen = 1'($urandom_range(0, 1));
            pLdsel = 1'($urandom_range(0, 1));
            pExu = $urandom;
            pLsu = $urandom;
         end
         pStall = ($urandom_range(0, 3) == 0);
         applyStimulus(pend, pPc, pRdid, pRdwen, pLdsel, pExu, pLsu, pStall, r, c, w);
         if (pend && r) pend = 1'b0;
      end
      tries = 0;
      while (sbQueue.size() != 0 && tries < 10) begin
         idleCycle(1'b0, r, c, w);
         tries++;
      end
      checkOutput("randomDrained", 64'(sbQueue.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
